// File: rtl/fifo_rd_packer_if.sv
// Read-side FIFO handshake plus the packed valid/ready output word of fifo_rd_packer.
// master is the packer's view; slave is the FIFO/downstream environment's view.
interface fifo_rd_packer_if #(
    parameter int DSIZE = 8,
    parameter int LANES = 4
);
    logic [DSIZE-1:0]       rdata;
    logic                   rempty;
    logic                   rinc;
    logic [DSIZE*LANES-1:0] out_data;
    logic [LANES-1:0]       out_keep;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        input  rdata, rempty, out_ready,
        output rinc, out_data, out_keep, out_valid
    );

    modport slave (
        output rdata, rempty, out_ready,
        input  rinc, out_data, out_keep, out_valid
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops first-word-fall-through FIFO entries and packs LANES of them little-endian
// into one output word; an idle timeout flushes a partially filled word.
module fifo_rd_packer #(
    parameter int DSIZE   = 8,
    parameter int LANES   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    fifo_rd_packer_if.master bus
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [LW-1:0] LAST_LANE  = LW'(LANES - 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                 state, state_n;
    logic [LW-1:0]          lane, lane_n;
    logic [IW-1:0]          idle, idle_n;
    logic [DSIZE*LANES-1:0] data_q, data_n;
    logic [LANES-1:0]       keep_q, keep_n;
    logic                   pop;

    assign pop           = (state == FILL) && !bus.rempty;
    assign bus.rinc      = pop && !rrst;
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = data_q;
    assign bus.out_keep  = keep_q;

    always_comb begin
        state_n = state;
        lane_n  = lane;
        idle_n  = idle;
        data_n  = data_q;
        keep_n  = keep_q;
        case (state)
            FILL: begin
                if (pop) begin
                    // A pop always wins over an expiring idle count.
                    for (int unsigned k = 0; k < LANES; k++) begin
                        if (lane == LW'(k)) begin
                            data_n[k*DSIZE +: DSIZE] = bus.rdata;
                            keep_n[k]                = 1'b1;
                        end
                    end
                    idle_n = '0;
                    if (lane == LAST_LANE) begin
                        lane_n  = '0;
                        state_n = HOLD;
                    end else begin
                        lane_n = lane + LW'(1);
                    end
                end else if (TIMEOUT != 0 && lane != '0) begin
                    if (idle == IDLE_LIMIT) begin
                        lane_n  = '0;
                        idle_n  = '0;
                        state_n = HOLD;
                    end else if (idle != '1) begin
                        idle_n = idle + IW'(1);
                    end
                end else begin
                    idle_n = '0;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    data_n  = '0;
                    keep_n  = '0;
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state  <= FILL;
            lane   <= '0;
            idle   <= '0;
            data_q <= '0;
            keep_q <= '0;
        end else begin
            state  <= state_n;
            lane   <= lane_n;
            idle   <= idle_n;
            data_q <= data_n;
            keep_q <= keep_n;
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: queue-based FIFO models feed two packers
// (TIMEOUT=16 and TIMEOUT=0); accepted words are compared against a chunking model.
module tb_fifo_rd_packer;
    localparam int DSIZE = 8;
    localparam int LANES = 4;
    localparam int TIMEOUT = 16;

    logic rclk = 1'b0;
    logic rrst = 1'b1;
    always #5 rclk = ~rclk;

    fifo_rd_packer_if #(.DSIZE(DSIZE), .LANES(LANES)) bus ();
    fifo_rd_packer_if #(.DSIZE(DSIZE), .LANES(LANES)) bus0 ();

    fifo_rd_packer #(.DSIZE(DSIZE), .LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
        .rclk(rclk), .rrst(rrst), .bus(bus)
    );
    fifo_rd_packer #(.DSIZE(DSIZE), .LANES(LANES), .TIMEOUT(0)) dut0 (
        .rclk(rclk), .rrst(rrst), .bus(bus0)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  fq[$];
    logic [7:0]  fq0[$];
    logic [7:0]  sent[$];
    logic [31:0] got_d[$];
    logic [3:0]  got_k[$];
    int          got_t[$];
    logic [31:0] got0_d[$];
    logic [3:0]  got0_k[$];
    logic [31:0] exp_d[$];
    logic [3:0]  exp_k[$];
    int pops = 0;
    int cnt = 0;
    int cyc = 0;
    int bad_rinc = 0;
    int valid0_cycles = 0;

    // FIFO model and output monitor for the TIMEOUT=16 packer. Signals are
    // sampled mid-cycle, the edge is applied, then the FIFO outputs are refreshed.
    initial begin
        logic s_rinc, s_empty, s_valid, s_ready;
        logic [31:0] s_d;
        logic [3:0] s_k;
        bus.rempty = 1'b1;
        bus.rdata  = '0;
        forever begin
            @(negedge rclk); #1;
            s_rinc = bus.rinc; s_empty = bus.rempty; s_valid = bus.out_valid;
            s_ready = bus.out_ready; s_d = bus.out_data; s_k = bus.out_keep;
            @(posedge rclk);
            cyc++;
            if (s_rinc && s_empty) bad_rinc++;
            if (s_rinc && fq.size() > 0) begin
                void'(fq.pop_front());
                pops++;
                cnt = 0;
            end else if (cnt < 1000000) begin
                cnt++;
            end
            if (s_valid && s_ready) begin
                got_d.push_back(s_d);
                got_k.push_back(s_k);
                got_t.push_back(cyc);
            end
            #1;
            bus.rempty = (fq.size() == 0);
            bus.rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
        end
    end

    initial begin
        logic t_rinc, t_valid, t_ready;
        logic [31:0] t_d;
        logic [3:0] t_k;
        bus0.rempty = 1'b1;
        bus0.rdata  = '0;
        forever begin
            @(negedge rclk); #1;
            t_rinc = bus0.rinc; t_valid = bus0.out_valid; t_ready = bus0.out_ready;
            t_d = bus0.out_data; t_k = bus0.out_keep;
            @(posedge rclk);
            if (t_valid) valid0_cycles++;
            if (t_rinc && fq0.size() > 0) void'(fq0.pop_front());
            if (t_valid && t_ready) begin
                got0_d.push_back(t_d);
                got0_k.push_back(t_k);
            end
            #1;
            bus0.rempty = (fq0.size() == 0);
            bus0.rdata  = (fq0.size() != 0) ? fq0[0] : 8'h00;
        end
    end

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        sent.push_back(b);
    endtask

    task automatic clear_all();
        got_d.delete(); got_k.delete(); got_t.delete(); sent.delete();
    endtask

    // Reference: consecutive entries grouped LANES at a time, first entry in the LSBs;
    // a short trailing group is zero-padded with keep set only for present entries.
    task automatic build_exp();
        logic [31:0] w;
        logic [3:0] k;
        exp_d.delete(); exp_k.delete();
        for (int i = 0; i < sent.size(); i += LANES) begin
            w = '0;
            k = '0;
            for (int j = 0; j < LANES && i + j < sent.size(); j++) begin
                w = w | (32'(sent[i+j]) << (8 * j));
                k = k | (4'd1 << j);
            end
            exp_d.push_back(w);
            exp_k.push_back(k);
        end
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        int k = 0;
        while (got_d.size() < n && k < budget) begin
            @(negedge rclk);
            k++;
        end
        ok = (got_d.size() >= n);
    endtask

    task automatic wait_pops(input int target, input int c, input int budget, output bit ok);
        int k = 0;
        do begin
            @(negedge rclk);
            k++;
        end while (!(pops == target && (c < 0 || cnt == c)) && k < budget);
        ok = (pops == target && (c < 0 || cnt == c));
    endtask

    task automatic test_reset();
        rrst = 1'b1;
        repeat (3) @(negedge rclk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
        checks++; if (bus.out_keep !== 4'h0) begin errors++; $display("FAIL reset_keep got=%b exp=0000", bus.out_keep); end
        checks++; if (bus.rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc got=%b exp=0", bus.rinc); end
        checks++; if (bus0.out_valid !== 1'b0 || bus0.out_keep !== 4'h0) begin
            errors++; $display("FAIL reset_dut0 valid=%b keep=%b exp 0/0000", bus0.out_valid, bus0.out_keep);
        end
        rrst = 1'b0;
        repeat (2) @(negedge rclk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_full_burst();
        bit ok;
        clear_all();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 120; i++) push(8'(i));
        build_exp();
        wait_got(30, 400, ok);
        repeat (20) @(negedge rclk);
        checks++; if (!ok || got_d.size() != 30) begin errors++; $display("FAIL burst_count got=%0d exp=30", got_d.size()); end
        if (got_d.size() == 30) begin
            checks++; if (got_d[0] !== 32'h04030201) begin errors++; $display("FAIL burst_first got=%h exp=04030201", got_d[0]); end
            checks++; if (got_d[29] !== 32'h78777675) begin errors++; $display("FAIL burst_last got=%h exp=78777675", got_d[29]); end
            checks++; if (got_t[29] - got_t[0] != 29 * (LANES + 1)) begin
                errors++; $display("FAIL burst_throughput got=%0d exp=%0d cycles", got_t[29] - got_t[0], 29 * (LANES + 1));
            end
        end
        for (int i = 0; i < exp_d.size(); i++) begin
            logic [31:0] gd;
            logic [3:0] gk;
            gd = (i < got_d.size()) ? got_d[i] : 32'hxxxxxxxx;
            gk = (i < got_k.size()) ? got_k[i] : 4'hx;
            checks++; if (gd !== exp_d[i] || gk !== 4'b1111) begin
                errors++; $display("FAIL burst_word%0d got=%h/%b exp=%h/1111", i, gd, gk, exp_d[i]);
            end
        end
        checks++; if (bad_rinc != 0) begin errors++; $display("FAIL burst_rinc_when_empty got=%0d exp=0", bad_rinc); end
    endtask

    task automatic test_partial_flush();
        bit ok;
        int base;
        clear_all();
        base = pops;
        for (int i = 1; i <= 6; i++) push(8'(i));
        build_exp();
        wait_pops(base + 6, 15, 120, ok);
        checks++; if (!ok) begin errors++; $display("FAIL flush_wait pops=%0d exp=%0d", pops - base, 6); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_early got=%b exp=0 at idle 15", bus.out_valid); end
        @(negedge rclk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_latency got=%b exp=1 at 16", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h00000605 || bus.out_keep !== 4'b0011) begin
            errors++; $display("FAIL flush_word got=%h/%b exp=00000605/0011", bus.out_data, bus.out_keep);
        end
        wait_got(2, 20, ok);
        checks++; if (got_d.size() != exp_d.size()) begin errors++; $display("FAIL flush_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size(); i++) begin
            logic [31:0] gd;
            logic [3:0] gk;
            gd = (i < got_d.size()) ? got_d[i] : 32'hxxxxxxxx;
            gk = (i < got_k.size()) ? got_k[i] : 4'hx;
            checks++; if (gd !== exp_d[i] || gk !== exp_k[i]) begin
                errors++; $display("FAIL flush_word%0d got=%h/%b exp=%h/%b", i, gd, gk, exp_d[i], exp_k[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int k = 0;
        int bad_d = 0;
        int bad_r = 0;
        clear_all();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 40; i++) push(8'(i));
        build_exp();
        while (bus.out_valid !== 1'b1 && k < 30) begin @(negedge rclk); k++; end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got=%b exp=1", bus.out_valid); end
        for (int c = 0; c < 50; c++) begin
            if (bus.out_data !== 32'h04030201 || bus.out_valid !== 1'b1) bad_d++;
            if (bus.rinc !== 1'b0) bad_r++;
            @(negedge rclk);
        end
        checks++; if (bad_d != 0) begin errors++; $display("FAIL bp_hold_word bad_cycles=%0d exp=0", bad_d); end
        checks++; if (bad_r != 0) begin errors++; $display("FAIL bp_rinc bad_cycles=%0d exp=0", bad_r); end
        checks++; if (fq.size() != 36) begin errors++; $display("FAIL bp_backlog got=%0d exp=36", fq.size()); end
        bus.out_ready = 1'b1;
        wait_got(10, 200, ok);
        repeat (5) @(negedge rclk);
        checks++; if (got_d.size() != 10) begin errors++; $display("FAIL bp_count got=%0d exp=10", got_d.size()); end
        for (int i = 0; i < exp_d.size(); i++) begin
            logic [31:0] gd;
            logic [3:0] gk;
            gd = (i < got_d.size()) ? got_d[i] : 32'hxxxxxxxx;
            gk = (i < got_k.size()) ? got_k[i] : 4'hx;
            checks++; if (gd !== exp_d[i] || gk !== exp_k[i]) begin
                errors++; $display("FAIL bp_word%0d got=%h/%b exp=%h/%b", i, gd, gk, exp_d[i], exp_k[i]);
            end
        end
    endtask

    task automatic test_timeout_race();
        bit ok;
        int base;
        logic [7:0] b[4];
        clear_all();
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
        base = pops;
        push(b[0]);
        push(b[1]);
        // Pushed at idle 14 so the entry is visible while the idle count sits at 15.
        wait_pops(base + 2, 14, 80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL race_setup pops=%0d cnt=%0d exp=2/14", pops - base, cnt); end
        push(b[2]);
        wait_pops(base + 3, -1, 10, ok);
        checks++; if (!ok || cnt != 0) begin errors++; $display("FAIL race_pop pops=%0d cnt=%0d exp=3/0", pops - base, cnt); end
        checks++; if (bus.out_valid !== 1'b0 || got_d.size() != 0) begin
            errors++; $display("FAIL race_flushed valid=%b words=%0d exp 0/0", bus.out_valid, got_d.size());
        end
        push(b[3]);
        wait_got(1, 30, ok);
        checks++; if (got_d.size() != 1) begin errors++; $display("FAIL race_count got=%0d exp=1", got_d.size()); end
        checks++; if (got_d.size() == 0 || got_d[0] !== {b[3], b[2], b[1], b[0]} || got_k[0] !== 4'b1111) begin
            errors++;
            $display("FAIL race_word got=%h/%b exp=%h/1111", (got_d.size() != 0) ? got_d[0] : 32'hx,
                     (got_k.size() != 0) ? got_k[0] : 4'hx, {b[3], b[2], b[1], b[0]});
        end
    endtask

    task automatic test_reset_mid_word();
        bit ok;
        int base;
        clear_all();
        base = pops;
        push(8'h11);
        push(8'h22);
        wait_pops(base + 2, -1, 20, ok);
        rrst = 1'b1;
        for (int i = 0; i < 4; i++) fq.push_back(8'hA0 + 8'(i));
        repeat (3) @(negedge rclk);
        checks++; if (bus.rinc !== 1'b0) begin errors++; $display("FAIL rst_rinc_forced got=%b exp=0 rempty=%b", bus.rinc, bus.rempty); end
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_keep !== 4'h0) begin
            errors++; $display("FAIL rst_outputs got=%b/%h/%b exp=0/0/0", bus.out_valid, bus.out_data, bus.out_keep);
        end
        rrst = 1'b0;
        wait_got(1, 30, ok);
        repeat (25) @(negedge rclk);
        checks++; if (got_d.size() != 1) begin errors++; $display("FAIL rst_count got=%0d exp=1", got_d.size()); end
        checks++; if (got_d.size() == 0 || got_d[0] !== 32'hA3A2A1A0 || got_k[0] !== 4'b1111) begin
            errors++;
            $display("FAIL rst_word got=%h/%b exp=a3a2a1a0/1111", (got_d.size() != 0) ? got_d[0] : 32'hx,
                     (got_k.size() != 0) ? got_k[0] : 4'hx);
        end
    endtask

    task automatic test_timeout0();
        int k = 0;
        logic [7:0] b[4];
        got0_d.delete(); got0_k.delete();
        bus0.out_ready = 1'b1;
        valid0_cycles = 0;
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 3; i++) fq0.push_back(b[i]);
        repeat (1000) @(negedge rclk);
        checks++; if (valid0_cycles != 0 || got0_d.size() != 0) begin
            errors++; $display("FAIL t0_no_flush valid_cycles=%0d words=%0d exp 0/0", valid0_cycles, got0_d.size());
        end
        fq0.push_back(b[3]);
        while (got0_d.size() < 1 && k < 20) begin @(negedge rclk); k++; end
        checks++; if (got0_d.size() != 1 || got0_d[0] !== {b[3], b[2], b[1], b[0]} || got0_k[0] !== 4'b1111) begin
            errors++;
            $display("FAIL t0_word words=%0d got=%h/%b exp=%h/1111", got0_d.size(), (got0_d.size() != 0) ? got0_d[0] : 32'hx,
                     (got0_k.size() != 0) ? got0_k[0] : 4'hx, {b[3], b[2], b[1], b[0]});
        end
    endtask

    task automatic test_random();
        bit ok;
        int n;
        int gap;
        clear_all();
        n = int'($urandom_range(40, 61));
        for (int i = 0; i < n; i++) begin
            push(8'($urandom_range(0, 255)));
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g <= gap; g++) begin
                @(negedge rclk);
                bus.out_ready = ($urandom_range(0, 9) < 7);
            end
        end
        bus.out_ready = 1'b1;
        build_exp();
        wait_got(exp_d.size(), 600, ok);
        repeat (30) @(negedge rclk);
        checks++; if (got_d.size() != exp_d.size()) begin
            errors++; $display("FAIL rand_count got=%0d exp=%0d (n=%0d)", got_d.size(), exp_d.size(), n);
        end
        for (int i = 0; i < exp_d.size(); i++) begin
            logic [31:0] gd;
            logic [3:0] gk;
            gd = (i < got_d.size()) ? got_d[i] : 32'hxxxxxxxx;
            gk = (i < got_k.size()) ? got_k[i] : 4'hx;
            checks++; if (gd !== exp_d[i] || gk !== exp_k[i]) begin
                errors++; $display("FAIL rand_word%0d got=%h/%b exp=%h/%b", i, gd, gk, exp_d[i], exp_k[i]);
            end
        end
        checks++; if (bad_rinc != 0) begin errors++; $display("FAIL rand_rinc_when_empty got=%0d exp=0", bad_rinc); end
    endtask

    initial begin
        bus.out_ready  = 1'b1;
        bus0.out_ready = 1'b1;
        test_reset();
        test_full_burst();
        test_partial_flush();
        test_backpressure();
        test_timeout_race();
        test_reset_mid_word();
        test_timeout0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the asynchronous FIFO. It runs entirely in the FIFO read clock domain and pops DSIZE-bit entries whenever the FIFO is non-empty. It packs LANES consecutive entries, little-endian, into one wide word and presents that word on a valid/ready output. A programmable idle timeout flushes a partially filled word so trailing data never stalls.

## Interface
- DSIZE, 8: width of one FIFO entry (bits).
- LANES, 4: entries per output word; 2..16.
- TIMEOUT, 16: `rclk` cycles of FIFO-empty with a partial word before flush; 0 disables flush.
- rclk  in  1  read-domain clock; the only clock.
- rrst  in  1  reset, asynchronous, active-high.
- rdata  in  DSIZE  FIFO read data; valid whenever `rempty`=0 (first-word fall-through).
- rempty  in  1  FIFO empty flag, synchronous to `rclk`.
- rinc  out  1  FIFO pop strobe; combinational.
- out_data  out  DSIZE*LANES  packed word; lane k occupies bits [k*DSIZE +: DSIZE].
- out_keep  out  LANES  per-lane valid mask for `out_data`.
- out_valid  out  1  output word available.
- out_ready  in  1  downstream accepts the word.

## Operation
- Two states: FILL and HOLD. Reset state is FILL.
- Internal registers:
  - `lane`: entry count, $clog2(LANES) bits.
  - `idle`: timeout counter, $clog2(TIMEOUT+1) bits, saturating.
  - `out_data`, `out_keep`.
- FILL behaviour:
  - `rinc` = (state==FILL) && !rempty && !rrst.
  - On each pop, `rdata` is written to lane `lane`, `out_keep[lane]` is set, `lane` increments, and `idle` clears.
  - The pop that fills lane LANES-1 sets `lane` to 0 and moves to HOLD with `out_valid`=1. `out_keep` is all ones.
- Flush:
  - Applies in FILL with TIMEOUT≠0, `lane`>0 and rempty=1.
  - `idle` increments each cycle.
  - When `idle` reaches TIMEOUT-1 while the FIFO is still empty, the block moves to HOLD with the partial word. `out_keep` holds ones only for filled lanes. Unfilled lanes of `out_data` are 0.
  - `lane` and `idle` clear on entering HOLD.
  - With `lane`=0, `idle` holds at 0; an empty packer never emits.
- HOLD behaviour:
  - `rinc`=0 and `out_valid`=1.
  - `out_data` and `out_keep` are stable until accepted.
  - When `out_valid` && `out_ready` at a rising edge, the block goes to FILL, clears `out_data` and `out_keep`, and deasserts `out_valid`.
- Data ordering: the first popped entry goes to lane 0 (LSBs). No entry is dropped or duplicated.
- Simultaneous events:
  - A pop in the same cycle that `idle` would expire takes priority. The pop is taken, `idle` clears, and there is no flush.
  - If the timeout expires on a pop that would also complete the word, the block emits a full word.
- Reset: asynchronous assert and synchronous-release use.
  - `out_valid`=0, `out_data`=0, `out_keep`=0, state FILL, `lane`=0, `idle`=0.
  - `rinc` is forced to 0 during reset.
  - Reset mid-word discards the partial word and any held word.

## Timing
- `rinc` is combinational from `rempty` and state. It is never asserted when `rempty`=1.
- Full-word latency: `out_valid` rises on the `rclk` edge that pops the LANES-th entry.
- Throughput: the packer spends LANES cycles in FILL and at least 1 cycle in HOLD. With a never-empty FIFO and `out_ready`=1, it emits one word per LANES+1 cycles.
- Backpressure: while `out_valid`=1 and `out_ready`=0, no pops occur and the FIFO absorbs the backlog.
- Flush latency: the partial word appears TIMEOUT cycles after the last pop, provided `rempty` stays 1.
- `out_ready` is sampled only in HOLD. `out_ready` asserted in FILL has no effect.

## Test plan
All scenarios use DSIZE=8, LANES=4, TIMEOUT=16, with the async FIFO upstream.

1. **Full burst.** Write 120 bytes, values 1..120, with `out_ready`=1.
   - 30 words.
   - First word 0x04030201, last word 0x78777675.
   - Every `out_keep`=4'b1111.
   - No `rinc` while `rempty`=1.
2. **Partial flush.** Write 6 bytes, values 1..6, then stop.
   - Word 0x04030201 with keep 1111.
   - Then, 16 cycles after the 6th pop, word 0x00000605 with keep 0011.
3. **Backpressure.** Burst of 40 bytes with `out_ready` low for 50 cycles after the first `out_valid`.
   - `out_data` stays 0x04030201 throughout.
   - `rinc` stays 0 throughout.
   - Afterwards, all 10 words arrive in order with no loss.
4. **Timeout vs pop race.** Deliver the 3rd byte exactly at idle count 15.
   - The byte is packed and there is no flush.
   - After a 4th byte, one word with keep 1111.
5. **Reset mid-word.** Assert `rrst` after 2 pops.
   - All outputs read 0 during reset.
   - After release and 4 new bytes 0xA0..0xA3, word 0xA3A2A1A0 with keep 1111.
   - No stale lanes.
6. **TIMEOUT=0 variant.** Write 3 bytes, then idle for 1000 cycles.
   - No output.
   - A 4th byte then yields a full word.
